rf_text_glyph_writer: RTL and testbench
=======================================

// Module: rf_text_glyph_writer
// PURPOSE
//  Write side of the text-mode character RAM. Accepts one glyph scanline bitmap per request.
//  Uses the same packed font addressing as the display-side glyph fetch to compute its byte address.
//  Issues one or two 64-bit byte-select bus writes into the char RAM, a second when the row straddles an octa-byte.
//  Sits between the font loader/CPU glue and the char RAM bus port.
// PARAMETERS
//  pCalcStages  2    pipeline cycles allowed for the address multiply/add (1..4)
//  pAckTimeout  255  clocks to wait for ack_i per bus write before aborting (1..255)
// PORTS
//  clk_i            in   1   system clock (char RAM bus clock)
//  rst_ni           in   1   reset, synchronous, active-low
//  req_i            in   1   request valid; transfer occurs when req_i & rdy_o
//  rdy_o            out  1   block idle, can accept a request
//  font_address_i   in   16  font base byte address; bits [2:0] ignored
//  char_code_i      in   13  character code
//  max_scan_pix_i   in   6   glyph width in pixels
//  max_scanline_i   in   6   glyph height in scanlines
//  scanline_i       in   6   scanline index within glyph
//  row_i            in   64  scanline bitmap, LSB-aligned; only low scan_width bytes are used
//  cs_o             out  1   bus cycle active
//  we_o             out  1   write strobe, equals cs_o
//  sel_o            out  8   byte lane selects
//  adr_o            out  13  octa-byte address [15:3]
//  dat_o            out  64  write data
//  ack_i            in   1   bus acknowledge, single cycle
//  done_o           out  1   one-cycle pulse, request complete
//  err_o            out  1   one-cycle pulse with done_o if a write timed out
// BEHAVIOUR
//  Reset (rst_ni=0 at clk edge): state IDLE.
//   cs_o, we_o, sel_o, adr_o, dat_o, done_o, err_o and rdy_o are all 0.
//   rdy_o goes to 1 on the first clock after reset is released.
//   Reset mid-transfer drops cs_o on the next edge. No partial second write.
//  Inputs are captured only on the handshake clock. Later changes to the inputs are ignored.
//  Arithmetic, unsigned, truncated to the stated widths:
//   sw   = max_scan_pix_i[5:3] + |max_scan_pix_i[2:0]      (4b, 0..8)
//   cs   = max_scanline_i * sw                              (10b)
//   cs8  = cs[9:3] + |cs[2:0]                               (7b)
//   badr = {font_address_i[15:3],3'b0} + char_code_i*{cs8,3'b0} + scanline_i*sw  (16b, wraps)
//   off  = badr[2:0]; m = (8'h01<<sw)-1 (m=8'hFF when sw=8)
//  FSM states IDLE -> CALC -> WR0 -> [WR1] -> DONE -> IDLE.
//   IDLE: rdy_o=1. On handshake, capture inputs and go to CALC.
//   CALC: lasts pCalcStages clocks. If sw==0, go to DONE with no bus cycle.
//   WR0: cs_o=we_o=1, adr_o=badr[15:3], sel_o=(m<<off)[7:0], dat_o=row<<{off,3'b0}.
//    Outputs are held stable until ack_i. On ack_i, go to WR1 if off+sw>8, else DONE.
//   WR1: adr_o=badr[15:3]+1 (13b wrap), sel_o=m>>(8-off), dat_o=row>>{8-off,3'b0}.
//    Outputs are held until ack_i, then go to DONE.
//   DONE: done_o=1 for one clock, cs_o=0, then IDLE.
//  cs_o is deasserted for at least one clock between WR0 and WR1.
//  ack_i is ignored while cs_o=0.
//  Timeout: a per-write counter clears on entry to WR0/WR1.
//   When it reaches pAckTimeout without ack_i: drop cs_o, skip any remaining write, pulse err_o with done_o.
//  ack_i on the same clock as the timeout terminal count: the ack wins and there is no error.
//  Throughput: one request in flight. rdy_o=0 from the handshake until DONE exits.
// TESTING
//  12x18 font, base 0, char 0x41, scanline 3, row=64'h0FFF, ack after 1 clk
//   -> single write: adr_o=13'h145, sel_o=8'hC0, dat_o=64'h0FFF<<48; done_o, err_o=0.
//  Same setup, scanline 4 -> adr_o=13'h146, sel_o=8'h03, dat_o=64'h0FFF.
//  Straddle: max_scan_pix=24, max_scanline=10, char 0, scanline 2, row=64'hABCDEF
//   -> WR0 adr 0, sel 8'hC0, dat row<<48.
//   -> WR1 adr 1, sel 8'h01, dat row>>16 (byte 0 = 8'hAB).
//  Timeout: pAckTimeout=4, ack_i held 0 -> cs_o drops after 4 clks.
//   -> done_o and err_o both pulse, no WR1, rdy_o returns to 1.
//  Wrap: base 16'hFFF8, badr=16'hFFFE, sw=3
//   -> WR0 adr 13'h1FFF sel 8'hC0; WR1 adr 13'h0000 sel 8'h01.
//  Reset asserted during WR0 with ack pending
//   -> next clk all outputs 0; after release rdy_o=1 and a new request completes normally.

Source files
------------

// File: rtl/rf_text_glyph_writer.sv
// rf_text_glyph_writer
//   Write side of the text-mode character RAM. Takes one glyph scanline bitmap
//   per request, computes its byte address with the same packed font layout the
//   display-side glyph fetch uses, and issues one or two 64-bit byte-select bus
//   writes (two when the scanline straddles an octa-byte boundary).
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_i / rdy_o        request handshake (transfer when req_i & rdy_o)
//   font_address_i       font base byte address, bits [2:0] ignored
//   char_code_i          character code
//   max_scan_pix_i       glyph width in pixels
//   max_scanline_i       glyph height in scanlines
//   scanline_i           scanline index within glyph
//   row_i                scanline bitmap, LSB-aligned
//   cs_o/we_o/sel_o/adr_o/dat_o/ack_i   char RAM bus write port
//   done_o               one-cycle completion pulse
//   err_o                pulses with done_o when a bus write timed out
module rf_text_glyph_writer #(
  parameter int unsigned pCalcStages = 2,
  parameter int unsigned pAckTimeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        rdy_o,
  input  logic [15:0] font_address_i,
  input  logic [12:0] char_code_i,
  input  logic [5:0]  max_scan_pix_i,
  input  logic [5:0]  max_scanline_i,
  input  logic [5:0]  scanline_i,
  input  logic [63:0] row_i,
  output logic        cs_o,
  output logic        we_o,
  output logic [7:0]  sel_o,
  output logic [12:0] adr_o,
  output logic [63:0] dat_o,
  input  logic        ack_i,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WR0,
    GAP,
    WR1,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  ccnt;
  logic [7:0]  tcnt;

  logic [15:0] font_q;
  logic [12:0] code_q;
  logic [5:0]  pix_q;
  logic [5:0]  lines_q;
  logic [5:0]  scan_q;
  logic [63:0] row_q;

  // Address datapath works from the captured request only; its result is not
  // consumed until CALC has run for pCalcStages clocks (multicycle path).
  logic [3:0]  sw;
  logic [9:0]  csz;
  logic [6:0]  cs8;
  logic [15:0] code_term;
  logic [15:0] scan_term;
  logic [15:0] badr;
  logic [2:0]  off;
  logic [7:0]  m;
  logic [3:0]  roff;
  logic [7:0]  sel0;
  logic [7:0]  sel1;
  logic [63:0] dat0;
  logic [63:0] dat1;
  logic        straddle;

  always_comb begin
    sw        = {1'b0, pix_q[5:3]} + {3'b000, |pix_q[2:0]};
    csz       = {4'b0000, lines_q} * {6'b000000, sw};
    cs8       = csz[9:3] + {6'b000000, |csz[2:0]};
    code_term = {3'b000, code_q} * {6'b000000, cs8, 3'b000};
    scan_term = {10'b0, scan_q} * {12'b0, sw};
    badr      = (font_q & 16'hFFF8) + code_term + scan_term;
    off       = badr[2:0];
    // Shifting 8'hFF by sw=8 leaves zero, so the inverse is the full mask.
    m         = ~(8'hFF << sw);
    roff      = 4'd8 - {1'b0, off};
    sel0      = m << off;
    dat0      = row_q << {off, 3'b000};
    sel1      = m >> roff;
    dat1      = row_q >> {roff, 3'b000};
    straddle  = ({1'b0, off} + sw) > 4'd8;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      rdy_o   <= 1'b0;
      cs_o    <= 1'b0;
      we_o    <= 1'b0;
      sel_o   <= '0;
      adr_o   <= '0;
      dat_o   <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      ccnt    <= '0;
      tcnt    <= '0;
      font_q  <= '0;
      code_q  <= '0;
      pix_q   <= '0;
      lines_q <= '0;
      scan_q  <= '0;
      row_q   <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          rdy_o <= 1'b1;
          if (req_i && rdy_o) begin
            rdy_o   <= 1'b0;
            font_q  <= font_address_i;
            code_q  <= char_code_i;
            pix_q   <= max_scan_pix_i;
            lines_q <= max_scanline_i;
            scan_q  <= scanline_i;
            row_q   <= row_i;
            ccnt    <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (ccnt == 3'(pCalcStages - 1)) begin
            if (sw == 4'd0) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              cs_o  <= 1'b1;
              we_o  <= 1'b1;
              adr_o <= badr[15:3];
              sel_o <= sel0;
              dat_o <= dat0;
              tcnt  <= '0;
              state <= WR0;
            end
          end else begin
            ccnt <= ccnt + 3'd1;
          end
        end
        WR0, WR1: begin
          if (ack_i && cs_o) begin
            cs_o  <= 1'b0;
            we_o  <= 1'b0;
            sel_o <= '0;
            adr_o <= '0;
            dat_o <= '0;
            if (state == WR0 && straddle) begin
              state <= GAP;
            end else begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          end else if (tcnt == 8'(pAckTimeout - 1)) begin
            cs_o   <= 1'b0;
            we_o   <= 1'b0;
            sel_o  <= '0;
            adr_o  <= '0;
            dat_o  <= '0;
            done_o <= 1'b1;
            err_o  <= 1'b1;
            state  <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        // One idle bus clock between the two writes of a straddling row.
        GAP: begin
          cs_o  <= 1'b1;
          we_o  <= 1'b1;
          adr_o <= badr[15:3] + 13'd1;
          sel_o <= sel1;
          dat_o <= dat1;
          tcnt  <= '0;
          state <= WR1;
        end
        DONE: begin
          rdy_o <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_text_glyph_writer.sv
// Testbench for rf_text_glyph_writer: randomized and directed requests, a
// byte-level reference model feeding a scoreboard, a bus responder with
// per-write acknowledge delays, and a monitor comparing bus writes and
// completions against the scoreboard.
module tb_rf_text_glyph_writer;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        rdy_o;
  logic [15:0] font_address_i;
  logic [12:0] char_code_i;
  logic [5:0]  max_scan_pix_i;
  logic [5:0]  max_scanline_i;
  logic [5:0]  scanline_i;
  logic [63:0] row_i;
  logic        cs_o;
  logic        we_o;
  logic [7:0]  sel_o;
  logic [12:0] adr_o;
  logic [63:0] dat_o;
  logic        ack_i;
  logic        done_o;
  logic        err_o;

  rf_text_glyph_writer #(
    .pCalcStages(2),
    .pAckTimeout(T)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .rdy_o         (rdy_o),
    .font_address_i(font_address_i),
    .char_code_i   (char_code_i),
    .max_scan_pix_i(max_scan_pix_i),
    .max_scanline_i(max_scanline_i),
    .scanline_i    (scanline_i),
    .row_i         (row_i),
    .cs_o          (cs_o),
    .we_o          (we_o),
    .sel_o         (sel_o),
    .adr_o         (adr_o),
    .dat_o         (dat_o),
    .ack_i         (ack_i),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [12:0] adr;
    logic [7:0]  sel;
    logic [63:0] dat;
  } wr_t;

  wr_t         exp_wr[$];
  logic        exp_done[$];
  int unsigned dly_q[$];

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{s[i]}};
    return r;
  endfunction

  // Reference: the scanline occupies sw consecutive bytes starting at the
  // glyph's byte address; group those bytes by octa-byte to get the writes.
  task automatic model(input logic [15:0] fa, input logic [12:0] cc, input logic [5:0] msp,
                       input logic [5:0] msl, input logic [5:0] sl, input logic [63:0] row,
                       input int unsigned d0, input int unsigned d1);
    int unsigned sw, gb, stride, badr, first, a, g, nw;
    logic err;
    wr_t w[2];
    sw     = (int'(msp) + 7) / 8;
    gb     = int'(msl) * sw;
    stride = ((gb + 7) / 8) * 8;
    badr   = ((int'(fa) / 8) * 8 + int'(cc) * stride + int'(sl) * sw) % 65536;
    first  = badr / 8;
    nw     = 0;
    for (int k = 0; k < 2; k++) begin
      w[k].adr = '0;
      w[k].sel = '0;
      w[k].dat = '0;
    end
    for (int unsigned i = 0; i < sw; i++) begin
      a = (badr + i) % 65536;
      g = (a / 8 == first) ? 0 : 1;
      w[g].adr = 13'(a / 8);
      w[g].sel[a % 8] = 1'b1;
      w[g].dat[(a % 8) * 8 +: 8] = row[i*8 +: 8];
      if (g + 1 > nw) nw = g + 1;
    end
    err = 1'b0;
    for (int unsigned k = 0; k < nw; k++) begin
      int unsigned d;
      d = (k == 0) ? d0 : d1;
      exp_wr.push_back(w[k]);
      dly_q.push_back(d);
      if (d >= T) begin
        err = 1'b1;
        break;
      end
    end
    exp_done.push_back(err);
  endtask

  task automatic send(input logic [15:0] fa, input logic [12:0] cc, input logic [5:0] msp,
                      input logic [5:0] msl, input logic [5:0] sl, input logic [63:0] row,
                      input int unsigned d0, input int unsigned d1);
    int unsigned n;
    n = 0;
    while (!rdy_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("rdy_wait", 64'(rdy_o), 64'd1);
    model(fa, cc, msp, msl, sl, row, d0, d1);
    req_i          = 1'b1;
    font_address_i = fa;
    char_code_i    = cc;
    max_scan_pix_i = msp;
    max_scanline_i = msl;
    scanline_i     = sl;
    row_i          = row;
    @(negedge clk);
    req_i          = 1'b0;
    font_address_i = 16'($urandom);
    char_code_i    = 13'($urandom);
    max_scan_pix_i = 6'($urandom);
    max_scanline_i = 6'($urandom);
    scanline_i     = 6'($urandom);
    row_i          = {$urandom, $urandom};
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_done.size() != 0 || !rdy_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_done.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cs"},   64'(cs_o),   64'd0);
    chk({tag, "_we"},   64'(we_o),   64'd0);
    chk({tag, "_sel"},  64'(sel_o),  64'd0);
    chk({tag, "_adr"},  64'(adr_o),  64'd0);
    chk({tag, "_dat"},  dat_o,       64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_err"},  64'(err_o),  64'd0);
    chk({tag, "_rdy"},  64'(rdy_o),  64'd0);
  endtask

  // Bus responder: acknowledges each write after its queued delay in clocks.
  initial begin
    int unsigned hi = 0;
    int unsigned dly = 0;
    logic prev = 1'b0;
    ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (cs_o && !prev) begin
        dly = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
        hi  = 0;
      end
      prev = cs_o;
      if (cs_o && !ack_i) begin
        if (hi == dly) ack_i = 1'b1;
        hi++;
      end else begin
        ack_i = 1'b0;
      end
    end
  end

  // Monitor: compares each new bus write and each completion.
  initial begin
    logic prev = 1'b0;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (cs_o && !prev) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 64'(cs_o), 64'd0);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_adr", 64'(adr_o), 64'(w.adr));
          chk("wr_sel", 64'(sel_o), 64'(w.sel));
          chk("wr_dat", dat_o & lane_mask(w.sel), w.dat);
          chk("wr_we",  64'(we_o), 64'd1);
        end
      end
      prev = cs_o;
      if (done_o) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 64'(done_o), 64'd0);
        end else begin
          chk("done_err", 64'(err_o), 64'(exp_done.pop_front()));
          chk("done_writes_left", 64'(exp_wr.size()), 64'd0);
        end
      end else if (err_o) begin
        chk("err_without_done", 64'(err_o), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d of %0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst_ni         = 1'b0;
    req_i          = 1'b0;
    font_address_i = '0;
    char_code_i    = '0;
    max_scan_pix_i = '0;
    max_scanline_i = '0;
    scanline_i     = '0;
    row_i          = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", 64'(rdy_o), 64'd1);

    // 12x18 font examples, single writes
    send(16'h0000, 13'h41, 6'd12, 6'd18, 6'd3, 64'h0FFF, 1, 0);
    send(16'h0000, 13'h41, 6'd12, 6'd18, 6'd4, 64'h0FFF, 0, 0);
    // straddling row
    send(16'h0000, 13'h0, 6'd24, 6'd10, 6'd2, 64'hABCDEF, 0, 2);
    // timeout on first write: no second write
    send(16'h0000, 13'h0, 6'd24, 6'd10, 6'd2, 64'hABCDEF, 100, 0);
    // address wrap, ack on the terminal-count clock of both writes
    send(16'hFFF8, 13'h0, 6'd24, 6'd10, 6'd2, 64'h123456, T - 1, T - 1);
    // timeout on the second write
    send(16'h0000, 13'h0, 6'd24, 6'd10, 6'd2, 64'h778899, 1, T);
    // zero-width glyph: no bus cycle
    send(16'h1234, 13'h7, 6'd0, 6'd9, 6'd1, 64'hFF, 0, 0);
    // full 8-byte width, odd base
    send(16'h0103, 13'h2, 6'd64 - 6'd1, 6'd5, 6'd1, 64'h0123456789ABCDEF, 2, 1);
    drain();

    for (int i = 0; i < 150; i++) begin
      int unsigned d0, d1;
      d0 = ($urandom_range(0, 9) < 8) ? $urandom_range(0, T - 1) : $urandom_range(T, T + 2);
      d1 = ($urandom_range(0, 9) < 8) ? $urandom_range(0, T - 1) : $urandom_range(T, T + 2);
      send(16'($urandom), 13'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
           {$urandom, $urandom}, d0, d1);
    end
    drain();

    // reset during the first write while the ack is still pending
    send(16'h0000, 13'h5, 6'd16, 6'd8, 6'd1, 64'hBEEF, 100, 0);
    n = 0;
    while (!cs_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_cs_seen", 64'(cs_o), 64'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    exp_wr.delete();
    exp_done.delete();
    dly_q.delete();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rdy_after_midreset", 64'(rdy_o), 64'd1);
    send(16'h0000, 13'h41, 6'd12, 6'd18, 6'd3, 64'h0FFF, 0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
